// File: rtl/mix_pkg.sv
// Shared types and stage arithmetic for the pipelined constant-mix datapath.
// Values are computed at 64 bits; callers keep the low OUT_W bits (mod 2^W).
package mix_pkg;

  localparam int MW = 64;

  typedef logic [MW-1:0] mw_t;

  typedef struct packed {
    mw_t  a;
    mw_t  b;
    mw_t  c;
    mw_t  d;
    logic mode;
  } mix_pay_t;

  function automatic mix_pay_t mix_s1(mw_t x);
    mix_pay_t p;
    p      = '0;
    p.a    = (x << 1) + x;
    p.b    = mw_t'(x[1:0]) * mw_t'(x[3:2]);
    return p;
  endfunction

  function automatic mix_pay_t mix_s2(mw_t a, mw_t b, mw_t k);
    mix_pay_t p;
    p   = '0;
    p.a = a;
    p.b = b;
    p.c = (a << 1) - k;
    p.d = b ^ k;
    return p;
  endfunction

  function automatic mw_t mix_s3(mw_t a, mw_t c, mw_t d);
    return (c ^ d) + a;
  endfunction

endpackage

// File: rtl/mix_stage_reg.sv
// Payload + valid pipeline register with enable and async reset.
module mix_stage_reg #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [PW-1:0] data_i,
  output logic          valid_o,
  output logic [PW-1:0] data_o
);

  logic          valid_q;
  logic [PW-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipelined_mix_datapath.sv
// Three-stage add/shift/xor/multiply mix against constant K with
// valid/ready backpressure, accumulate mode and a handshake counter.
module pipelined_mix_datapath
  import mix_pkg::*;
#(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned OUT_W = 10,
  parameter int          K     = 66,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  input_data,
  input  logic             in_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] output_data,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned W = OUT_W;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
  } s1_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic         mode;
  } s2_t;

  logic         en;
  mix_pay_t     f1;
  mix_pay_t     f2;
  s1_t          s1_d;
  s1_t          s1_q;
  logic         s1_v_q;
  s2_t          s2_d;
  s2_t          s2_q;
  logic         s2_v_q;
  logic [W-1:0] r;
  logic [W-1:0] acc_base;
  logic [W-1:0] acc_sum;
  logic         out_v_d;
  logic         out_v_q;
  logic [W-1:0] out_d;
  logic [W-1:0] out_q;
  logic [W-1:0] acc_d;
  logic [W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic         unused_bits;

  // Single global stall: the whole pipe freezes while the output is held.
  assign en       = !out_v_q || out_ready;
  assign in_ready = en && !rst;

  always_comb begin
    f1        = mix_s1(mw_t'(input_data));
    s1_d.a    = W'(f1.a);
    s1_d.b    = W'(f1.b);
    s1_d.mode = in_mode;
  end

  mix_stage_reg #(.PW($bits(s1_t))) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .valid_i (in_valid),
    .data_i  (s1_d),
    .valid_o (s1_v_q),
    .data_o  (s1_q)
  );

  always_comb begin
    f2 = mix_s2(mw_t'(s1_q.a), mw_t'(s1_q.b), mw_t'(K));
    s2_d.a    = W'(f2.a);
    s2_d.c    = W'(f2.c);
    s2_d.d    = W'(f2.d);
    s2_d.mode = s1_q.mode;
  end

  mix_stage_reg #(.PW($bits(s2_t))) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en),
    .valid_i (s1_v_q),
    .data_i  (s2_d),
    .valid_o (s2_v_q),
    .data_o  (s2_q)
  );

  assign unused_bits = ^{f1, f2};

  // Clear takes effect before a coinciding accumulate.
  always_comb begin
    r = W'(mix_s3(mw_t'(s2_q.a), mw_t'(s2_q.c), mw_t'(s2_q.d)));
    acc_base = acc_clr ? '0 : acc_q;
    acc_sum  = acc_base + r;
    out_v_d  = out_v_q;
    out_d    = out_q;
    acc_d    = acc_base;
    if (en) begin
      out_v_d = s2_v_q;
      if (s2_v_q) begin
        if (s2_q.mode) begin
          out_d = acc_sum;
          acc_d = acc_sum;
        end else begin
          out_d = r;
        end
      end
    end
    cnt_d = cnt_q + CNT_W'(out_v_q && out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q <= 1'b0;
      out_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      out_v_q <= out_v_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = out_v_q;
  assign output_data = out_q;
  assign txn_count   = cnt_q;

endmodule

// File: tb/tb_pipelined_mix_datapath.sv
// Scoreboard bench: driver pushes expected results, negedge monitor pops.
module tb_pipelined_mix_datapath;

  localparam int IN_W  = 6;
  localparam int OUT_W = 10;
  localparam int K     = 66;
  localparam int CNT_W = 4;
  localparam int MASK  = (1 << OUT_W) - 1;

  typedef struct {
    int val;
    int stamp;
    bit lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  input_data = '0;
  logic             in_mode = 1'b0;
  logic             acc_clr = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] output_data;
  logic [CNT_W-1:0] txn_count;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_hs = 0;
  int   m_acc = 0;

  pipelined_mix_datapath #(
    .IN_W(IN_W), .OUT_W(OUT_W), .K(K), .CNT_W(CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_data  (input_data),
    .in_mode     (in_mode),
    .acc_clr     (acc_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_data (output_data),
    .txn_count   (txn_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_r(int x);
    int a, b, c, d;
    a = 3 * x;
    b = (x % 4) * ((x / 4) % 4);
    c = (2 * a - K) & MASK;
    d = (b ^ K) & MASK;
    return ((c ^ d) + a) & MASK;
  endfunction

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Model: words retire in order, so the accumulator advances at accept time.
  function automatic void push(int x, bit mode, bit clr, bit lat);
    exp_t e;
    int   r;
    r = ref_r(x);
    if (clr) m_acc = 0;
    if (mode) begin
      m_acc = (m_acc + r) & MASK;
      e.val = m_acc;
    end else begin
      e.val = r;
    end
    e.stamp = cyc;
    e.lat   = lat;
    q.push_back(e);
  endfunction

  task automatic send(int x, bit mode, bit clr, bit lat);
    bit ok;
    ok = 1'b0;
    in_valid   = 1'b1;
    input_data = IN_W'(x);
    in_mode    = mode;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push(x, mode, clr, lat);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic pulse_clr();
    acc_clr = 1'b1;
    m_acc   = 0;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("txn_count", int'(txn_count), n_hs % (1 << CNT_W));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", int'(output_data), -1);
        end else begin
          chk("output_data", int'(output_data), q[0].val);
          if (out_ready) begin
            if (q[0].lat) chk("latency", cyc - q[0].stamp, 3);
            void'(q.pop_front());
          end
        end
        if (out_ready) n_hs++;
      end
    end
  end

  initial begin
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_output_data", int'(output_data), 0);
    chk("rst_txn_count", int'(txn_count), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", int'(in_ready), 1);

    // Mode 0 back-to-back, latency 3
    send(5, 0, 0, 1);
    send(0, 0, 0, 1);
    send(63, 0, 0, 1);
    drain();
    chk("txn_after_t1", int'(txn_count), 3);

    // Accumulate from cleared state
    pulse_clr();
    send(5, 1, 0, 0);
    send(0, 1, 0, 0);
    drain();

    // Backpressure with a clear landing during the stall
    out_ready = 1'b0;
    send(5, 0, 0, 0);
    send(0, 0, 0, 0);
    send(63, 0, 0, 0);
    in_valid   = 1'b1;
    input_data = IN_W'(5);
    in_mode    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    pulse_clr();
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(5, 0, 0, 0);
    send(5, 1, 0, 0);
    drain();

    // Clear coinciding with a mode-1 load into the output stage
    send(0, 1, 1, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    drain();

    // Reset with words in flight
    send(7, 1, 0, 0);
    send(9, 1, 0, 0);
    send(11, 1, 0, 0);
    rst      = 1'b1;
    in_valid = 1'b0;
    q.delete();
    n_hs  = 0;
    m_acc = 0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_txn", int'(txn_count), 0);
    chk("mid_rst_data", int'(output_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(63, 0, 0, 1);
    send(5, 1, 0, 1);
    for (int i = 0; i < 15; i++)
      send(int'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0);
    drain();
    idle(2);
    chk("txn_wrap", int'(txn_count), 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      input_data = IN_W'($urandom);
      in_mode    = $urandom % 2;
      out_ready  = ($urandom % 3) != 0;
      @(negedge clk);
      if (in_valid && in_ready) push(int'(input_data), in_mode, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
